// File: rtl/axil_pkg.sv
// Shared AXI4-Lite types, widths and address-decode helper for the
// control-plane slaves.
package axil_pkg;

    localparam int DATA_W = 32;
    localparam int STRB_W = 4;

    typedef enum logic [1:0] {
        OKAY   = 2'b00,
        EXOKAY = 2'b01,
        SLVERR = 2'b10,
        DECERR = 2'b11
    } resp_t;

    typedef enum logic [1:0] {
        W_IDLE,
        W_HAVE_AW,
        W_HAVE_W,
        W_RESP
    } wr_state_t;

    typedef enum logic {
        R_IDLE,
        R_DATA
    } rd_state_t;

    // Byte offset of an access relative to the start of the register bank.
    function automatic logic [31:0] addr_offset(input logic [31:0] addr,
                                                input logic [31:0] base);
        return addr - base;
    endfunction

endpackage

// File: rtl/axils_wr_ch.sv
// AXI4-Lite write engine: captures AW and W independently, decodes the
// target register and drives the B response plus a commit strobe.
//
// state      | meaning
// W_IDLE     | waiting for both AW and W
// W_HAVE_AW  | address latched, waiting for write data
// W_HAVE_W   | data latched, waiting for write address
// W_RESP     | write committed, holding BVALID until BREADY
module axils_wr_ch
    import axil_pkg::*;
#(
    parameter int          NUM_REGS  = 16,
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
    parameter int          IDX_W     = $clog2(NUM_REGS)
) (
    input  logic              ACLK,
    input  logic              ARESET,
    input  logic [31:0]       AWADDR,
    input  logic              AWVALID,
    output logic              AWREADY,
    input  logic [DATA_W-1:0] WDATA,
    input  logic [STRB_W-1:0] WSTRB,
    input  logic              WVALID,
    output logic              WREADY,
    output logic              BVALID,
    input  logic              BREADY,
    output logic [1:0]        BRESP,
    output logic              commit_valid,
    output logic [IDX_W-1:0]  commit_idx,
    output logic [DATA_W-1:0] commit_data,
    output logic [STRB_W-1:0] commit_strb
);

    wr_state_t         state_q, state_d;
    logic              awready_q, wready_q, bvalid_q;
    resp_t             bresp_q;
    logic [31:0]       awaddr_q;
    logic [DATA_W-1:0] wdata_q;
    logic [STRB_W-1:0] wstrb_q;

    logic        aw_hs, w_hs, do_commit, hit;
    logic [31:0] commit_addr, commit_off;

    assign aw_hs = AWVALID & awready_q;
    assign w_hs  = WVALID & wready_q;

    // The second half of a write may arrive on the commit edge itself.
    assign commit_addr = aw_hs ? AWADDR : awaddr_q;
    assign commit_data = w_hs ? WDATA : wdata_q;
    assign commit_strb = w_hs ? WSTRB : wstrb_q;
    assign commit_off  = addr_offset(commit_addr, BASE_ADDR);
    assign hit         = commit_off < 32'(NUM_REGS * 4);
    assign commit_idx  = commit_off[IDX_W+1:2];
    assign commit_valid = do_commit & hit;

    always_comb begin
        state_d   = state_q;
        do_commit = 1'b0;
        case (state_q)
            W_IDLE: begin
                if (aw_hs && w_hs) begin
                    do_commit = 1'b1;
                    state_d   = W_RESP;
                end else if (aw_hs) begin
                    state_d = W_HAVE_AW;
                end else if (w_hs) begin
                    state_d = W_HAVE_W;
                end
            end
            W_HAVE_AW: begin
                if (w_hs) begin
                    do_commit = 1'b1;
                    state_d   = W_RESP;
                end
            end
            W_HAVE_W: begin
                if (aw_hs) begin
                    do_commit = 1'b1;
                    state_d   = W_RESP;
                end
            end
            W_RESP: begin
                if (BREADY) state_d = W_IDLE;
            end
            default: state_d = W_IDLE;
        endcase
    end

    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            state_q   <= W_IDLE;
            awready_q <= 1'b0;
            wready_q  <= 1'b0;
            bvalid_q  <= 1'b0;
            bresp_q   <= OKAY;
            awaddr_q  <= '0;
            wdata_q   <= '0;
            wstrb_q   <= '0;
        end else begin
            state_q   <= state_d;
            awready_q <= (state_d == W_IDLE) || (state_d == W_HAVE_W);
            wready_q  <= (state_d == W_IDLE) || (state_d == W_HAVE_AW);
            bvalid_q  <= (state_d == W_RESP);
            if (aw_hs) awaddr_q <= AWADDR;
            if (w_hs) begin
                wdata_q <= WDATA;
                wstrb_q <= WSTRB;
            end
            if (do_commit) bresp_q <= hit ? OKAY : SLVERR;
        end
    end

    assign AWREADY = awready_q;
    assign WREADY  = wready_q;
    assign BVALID  = bvalid_q;
    assign BRESP   = bresp_q;

endmodule

// File: rtl/axils_regfile.sv
// AXI4-Lite register bank: NUM_REGS x 32-bit registers with byte strobes,
// per-register write pulses and an independent read engine.
//
// state   | meaning
// R_IDLE  | ARREADY high, waiting for a read address
// R_DATA  | read data registered, holding RVALID until RREADY
module axils_regfile
    import axil_pkg::*;
#(
    parameter int          NUM_REGS  = 16,
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
    input  logic                     ARESET,
    input  logic                     ACLK,
    input  logic [31:0]              AWADDR,
    input  logic [2:0]               AWPROT,
    input  logic                     AWVALID,
    output logic                     AWREADY,
    input  logic [DATA_W-1:0]        WDATA,
    input  logic [STRB_W-1:0]        WSTRB,
    input  logic                     WVALID,
    output logic                     WREADY,
    output logic                     BVALID,
    input  logic                     BREADY,
    output logic [1:0]               BRESP,
    input  logic [31:0]              ARADDR,
    input  logic [2:0]               ARPROT,
    input  logic                     ARVALID,
    output logic                     ARREADY,
    output logic [DATA_W-1:0]        RDATA,
    output logic [1:0]               RRESP,
    output logic                     RVALID,
    input  logic                     RREADY,
    output logic [NUM_REGS*32-1:0]   REG_Q,
    output logic [NUM_REGS-1:0]      REG_WE
);

    localparam int IDX_W = $clog2(NUM_REGS);

    logic [DATA_W-1:0] regs_q [NUM_REGS];
    logic [NUM_REGS-1:0] reg_we_q;

    logic              commit_valid;
    logic [IDX_W-1:0]  commit_idx;
    logic [DATA_W-1:0] commit_data;
    logic [STRB_W-1:0] commit_strb;

    // Protection attributes carry no meaning for this bank.
    logic unused_prot;
    assign unused_prot = ^{AWPROT, ARPROT};

    axils_wr_ch #(
        .NUM_REGS  (NUM_REGS),
        .BASE_ADDR (BASE_ADDR),
        .IDX_W     (IDX_W)
    ) u_wr_ch (
        .ACLK         (ACLK),
        .ARESET       (ARESET),
        .AWADDR       (AWADDR),
        .AWVALID      (AWVALID),
        .AWREADY      (AWREADY),
        .WDATA        (WDATA),
        .WSTRB        (WSTRB),
        .WVALID       (WVALID),
        .WREADY       (WREADY),
        .BVALID       (BVALID),
        .BREADY       (BREADY),
        .BRESP        (BRESP),
        .commit_valid (commit_valid),
        .commit_idx   (commit_idx),
        .commit_data  (commit_data),
        .commit_strb  (commit_strb)
    );

    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
            reg_we_q <= '0;
        end else begin
            reg_we_q <= '0;
            if (commit_valid) begin
                reg_we_q[commit_idx] <= 1'b1;
                for (int j = 0; j < STRB_W; j++) begin
                    if (commit_strb[j]) regs_q[commit_idx][8*j +: 8] <= commit_data[8*j +: 8];
                end
            end
        end
    end

    rd_state_t         rd_state_q, rd_state_d;
    logic              arready_q, rvalid_q;
    logic [DATA_W-1:0] rdata_q;
    resp_t             rresp_q;
    logic              ar_hs, ar_hit;
    logic [31:0]       ar_off;
    logic [IDX_W-1:0]  ar_idx;

    assign ar_hs  = ARVALID & arready_q;
    assign ar_off = addr_offset(ARADDR, BASE_ADDR);
    assign ar_hit = ar_off < 32'(NUM_REGS * 4);
    assign ar_idx = ar_off[IDX_W+1:2];

    always_comb begin
        rd_state_d = rd_state_q;
        case (rd_state_q)
            R_IDLE:  if (ar_hs) rd_state_d = R_DATA;
            R_DATA:  if (RREADY) rd_state_d = R_IDLE;
            default: rd_state_d = R_IDLE;
        endcase
    end

    // regs_q is sampled before any same-edge write lands, giving pre-write data.
    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            rd_state_q <= R_IDLE;
            arready_q  <= 1'b0;
            rvalid_q   <= 1'b0;
            rdata_q    <= '0;
            rresp_q    <= OKAY;
        end else begin
            rd_state_q <= rd_state_d;
            arready_q  <= (rd_state_d == R_IDLE);
            rvalid_q   <= (rd_state_d == R_DATA);
            if (ar_hs) begin
                rdata_q <= ar_hit ? regs_q[ar_idx] : '0;
                rresp_q <= ar_hit ? OKAY : SLVERR;
            end
        end
    end

    assign ARREADY = arready_q;
    assign RVALID  = rvalid_q;
    assign RDATA   = rdata_q;
    assign RRESP   = rresp_q;
    assign REG_WE  = reg_we_q;

    for (genvar i = 0; i < NUM_REGS; i++) begin : g_reg_q
        assign REG_Q[32*i +: 32] = regs_q[i];
    end

endmodule

// File: tb/tb_axils_regfile.sv
// Directed bench for axils_regfile: handshake timing, strobes, decode
// errors, back-pressure, read/write collision and mid-write reset.
module tb_axils_regfile;

    logic         aclk = 1'b0;
    logic         areset = 1'b1;
    logic [31:0]  awaddr = 32'h0;
    logic [2:0]   awprot = 3'h0;
    logic         awvalid = 1'b0;
    logic         awready;
    logic [31:0]  wdata = 32'h0;
    logic [3:0]   wstrb = 4'h0;
    logic         wvalid = 1'b0;
    logic         wready;
    logic         bvalid;
    logic         bready = 1'b0;
    logic [1:0]   bresp;
    logic [31:0]  araddr = 32'h0;
    logic [2:0]   arprot = 3'h0;
    logic         arvalid = 1'b0;
    logic         arready;
    logic [31:0]  rdata;
    logic [1:0]   rresp;
    logic         rvalid;
    logic         rready = 1'b0;
    logic [511:0] reg_q;
    logic [15:0]  reg_we;

    int checks = 0;
    int errors = 0;

    always #5 aclk = ~aclk;

    axils_regfile #(
        .NUM_REGS  (16),
        .BASE_ADDR (32'h0000_0000)
    ) dut (
        .ARESET  (areset),
        .ACLK    (aclk),
        .AWADDR  (awaddr),
        .AWPROT  (awprot),
        .AWVALID (awvalid),
        .AWREADY (awready),
        .WDATA   (wdata),
        .WSTRB   (wstrb),
        .WVALID  (wvalid),
        .WREADY  (wready),
        .BVALID  (bvalid),
        .BREADY  (bready),
        .BRESP   (bresp),
        .ARADDR  (araddr),
        .ARPROT  (arprot),
        .ARVALID (arvalid),
        .ARREADY (arready),
        .RDATA   (rdata),
        .RRESP   (rresp),
        .RVALID  (rvalid),
        .RREADY  (rready),
        .REG_Q   (reg_q),
        .REG_WE  (reg_we)
    );

    task automatic chk1(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk2(input string tag, input logic [1:0] obs, input logic [1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk16(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk512(input string tag, input logic [511:0] obs, input logic [511:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge aclk);
        #1;
    endtask

    task automatic do_write(input logic [31:0] addr, input logic [31:0] data,
                            input logic [3:0] strb, output logic [1:0] resp,
                            output logic [15:0] we);
        awaddr = addr; wdata = data; wstrb = strb;
        awvalid = 1'b1; wvalid = 1'b1;
        tick();
        awvalid = 1'b0; wvalid = 1'b0;
        for (int i = 0; i < 8 && bvalid !== 1'b1; i++) tick();
        chk1("wr_bvalid", bvalid, 1'b1);
        resp = bresp;
        we   = reg_we;
        bready = 1'b1;
        tick();
        bready = 1'b0;
    endtask

    task automatic do_read(input logic [31:0] addr, output logic [31:0] data,
                           output logic [1:0] resp);
        araddr = addr; arvalid = 1'b1;
        tick();
        arvalid = 1'b0;
        for (int i = 0; i < 8 && rvalid !== 1'b1; i++) tick();
        chk1("rd_rvalid", rvalid, 1'b1);
        data = rdata;
        resp = rresp;
        rready = 1'b1;
        tick();
        rready = 1'b0;
    endtask

    initial begin
        logic [1:0]   resp;
        logic [15:0]  we;
        logic [31:0]  data;
        logic [511:0] exp_q;

        // Reset values while ARESET is held.
        #2;
        chk1("rst_awready", awready, 1'b0);
        chk1("rst_wready", wready, 1'b0);
        chk1("rst_arready", arready, 1'b0);
        chk1("rst_bvalid", bvalid, 1'b0);
        chk1("rst_rvalid", rvalid, 1'b0);
        chk2("rst_bresp", bresp, 2'b00);
        chk2("rst_rresp", rresp, 2'b00);
        chk32("rst_rdata", rdata, 32'h0);
        chk512("rst_reg_q", reg_q, 512'h0);
        chk16("rst_reg_we", reg_we, 16'h0);
        #10;
        areset = 1'b0;
        tick();
        chk1("post_rst_awready", awready, 1'b1);
        chk1("post_rst_wready", wready, 1'b1);
        chk1("post_rst_arready", arready, 1'b1);

        // AW and W in the same cycle.
        awaddr = 32'h8; wdata = 32'hDEADBEEF; wstrb = 4'hF;
        awvalid = 1'b1; wvalid = 1'b1;
        tick();
        awvalid = 1'b0; wvalid = 1'b0;
        chk1("t1_bvalid", bvalid, 1'b1);
        chk2("t1_bresp", bresp, 2'b00);
        chk32("t1_reg2", reg_q[95:64], 32'hDEADBEEF);
        chk16("t1_reg_we", reg_we, 16'h0004);
        chk1("t1_awready_busy", awready, 1'b0);
        chk1("t1_wready_busy", wready, 1'b0);
        bready = 1'b1;
        tick();
        bready = 1'b0;
        chk1("t1_bvalid_drop", bvalid, 1'b0);
        chk16("t1_reg_we_drop", reg_we, 16'h0000);
        chk1("t1_awready_back", awready, 1'b1);
        chk1("t1_wready_back", wready, 1'b1);

        // W three cycles ahead of AW, partial strobes.
        do_write(32'h4, 32'hAAAAAAAA, 4'hF, resp, we);
        chk2("t2_pre_bresp", resp, 2'b00);
        wdata = 32'h11223344; wstrb = 4'b0101; wvalid = 1'b1;
        tick();
        wvalid = 1'b0;
        chk1("t2_wready_held", wready, 1'b0);
        chk1("t2_awready_open", awready, 1'b1);
        chk1("t2_no_bvalid", bvalid, 1'b0);
        tick();
        tick();
        chk1("t2_wready_still", wready, 1'b0);
        awaddr = 32'h4; awvalid = 1'b1;
        tick();
        awvalid = 1'b0;
        chk1("t2_bvalid", bvalid, 1'b1);
        chk32("t2_reg1", reg_q[63:32], 32'hAA22AA44);
        chk16("t2_reg_we", reg_we, 16'h0002);
        chk1("t2_wready_resp", wready, 1'b0);
        bready = 1'b1;
        tick();
        bready = 1'b0;
        chk1("t2_wready_back", wready, 1'b1);

        // Out-of-range read and write.
        do_read(32'h40, data, resp);
        chk32("t3_rdata", data, 32'h0);
        chk2("t3_rresp", resp, 2'b10);
        do_write(32'h40, 32'hFFFFFFFF, 4'hF, resp, we);
        chk2("t3_bresp", resp, 2'b10);
        chk16("t3_reg_we", we, 16'h0000);
        exp_q = 512'h0;
        exp_q[63:32] = 32'hAA22AA44;
        exp_q[95:64] = 32'hDEADBEEF;
        chk512("t3_reg_q", reg_q, exp_q);

        // Back-pressure on both response channels.
        awaddr = 32'h14; wdata = 32'h12345678; wstrb = 4'hF;
        awvalid = 1'b1; wvalid = 1'b1;
        araddr = 32'h8; arvalid = 1'b1;
        tick();
        awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            chk1("t4_bvalid", bvalid, 1'b1);
            chk2("t4_bresp", bresp, 2'b00);
            chk1("t4_rvalid", rvalid, 1'b1);
            chk32("t4_rdata", rdata, 32'hDEADBEEF);
            chk2("t4_rresp", rresp, 2'b00);
            chk1("t4_awready", awready, 1'b0);
            chk1("t4_wready", wready, 1'b0);
            chk1("t4_arready", arready, 1'b0);
            tick();
        end
        chk1("t4_bvalid_end", bvalid, 1'b1);
        chk1("t4_rvalid_end", rvalid, 1'b1);
        bready = 1'b1; rready = 1'b1;
        tick();
        bready = 1'b0; rready = 1'b0;
        chk1("t4_bvalid_drop", bvalid, 1'b0);
        chk1("t4_rvalid_drop", rvalid, 1'b0);
        chk1("t4_awready_back", awready, 1'b1);
        chk1("t4_arready_back", arready, 1'b1);
        chk32("t4_reg5", reg_q[191:160], 32'h12345678);

        // Same-edge write and read of reg3.
        do_write(32'hC, 32'h9, 4'hF, resp, we);
        chk32("t5_reg3_pre", reg_q[127:96], 32'h9);
        awaddr = 32'hC; wdata = 32'h5; wstrb = 4'hF;
        awvalid = 1'b1; wvalid = 1'b1;
        araddr = 32'hC; arvalid = 1'b1;
        tick();
        awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
        chk1("t5_rvalid", rvalid, 1'b1);
        chk32("t5_rdata_old", rdata, 32'h9);
        chk32("t5_reg3_new", reg_q[127:96], 32'h5);
        bready = 1'b1; rready = 1'b1;
        tick();
        bready = 1'b0; rready = 1'b0;
        do_read(32'hC, data, resp);
        chk32("t5_rdata_new", data, 32'h5);
        chk2("t5_rresp", resp, 2'b00);

        // Reset between AW capture and W.
        awaddr = 32'h10; awvalid = 1'b1;
        tick();
        awvalid = 1'b0;
        chk1("t6_awready_captured", awready, 1'b0);
        chk1("t6_wready_open", wready, 1'b1);
        areset = 1'b1;
        #2;
        chk1("t6_rst_bvalid", bvalid, 1'b0);
        chk512("t6_rst_reg_q", reg_q, 512'h0);
        chk1("t6_rst_awready", awready, 1'b0);
        areset = 1'b0;
        tick();
        chk1("t6_awready_up", awready, 1'b1);
        wdata = 32'h77; wstrb = 4'hF; wvalid = 1'b1;
        tick();
        wvalid = 1'b0;
        chk1("t6_no_commit", bvalid, 1'b0);
        chk512("t6_reg_q_zero", reg_q, 512'h0);
        chk1("t6_wready_captured", wready, 1'b0);
        awaddr = 32'h10; awvalid = 1'b1;
        tick();
        awvalid = 1'b0;
        chk1("t6_bvalid", bvalid, 1'b1);
        chk32("t6_reg4", reg_q[159:128], 32'h77);
        chk16("t6_reg_we", reg_we, 16'h0010);
        bready = 1'b1;
        tick();
        bready = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/axils_regfile.md
# axils_regfile

AXI4-Lite slave terminating the bus driven by the team's AXI4-Lite master and exposing a bank of NUM_REGS 32-bit read/write registers to local logic. It has independent write and read channel engines, byte-lane write strobes, SLVERR on out-of-range addresses, and a one-cycle write-enable pulse per register for local side effects. It sits at the peripheral end of the control-plane interconnect.

## Interface
- NUM_REGS, 16: number of 32-bit registers; power of two, 2..256.
- BASE_ADDR, 32'h0000_0000: byte address of register 0; aligned to NUM_REGS*4.
- ARESET  in  1: asynchronous, active-high reset.
- ACLK  in  1: single clock; all logic is on its rising edge.
- AWADDR in 32, AWPROT in 3, AWVALID in 1, AWREADY out 1: write address channel.
- WDATA in 32, WSTRB in 4, WVALID in 1, WREADY out 1: write data channel.
- BVALID out 1, BREADY in 1, BRESP out 2: write response channel.
- ARADDR in 32, ARPROT in 3, ARVALID in 1, ARREADY out 1: read address channel.
- RDATA out 32, RRESP out 2, RVALID out 1, RREADY in 1: read data channel.
- REG_Q  out  NUM_REGS*32: flat register contents; register i is at bits [32i+31:32i].
- REG_WE  out  NUM_REGS: one-cycle pulse, bit i high in the cycle after register i is written.

## Operation
- Decode: offset = ADDR − BASE_ADDR. Hit when offset < NUM_REGS*4. Index = offset[log2(NUM_REGS)+1:2]. ADDR[1:0] and the PROT inputs are ignored.
- Write engine states: W_IDLE, W_HAVE_AW, W_HAVE_W, W_RESP.
  - AW and W are accepted independently, in any order or in the same cycle. Each is latched on its handshake.
  - After a channel is captured, its READY stays low until the B handshake completes.
  - Commit happens at the edge where the second of AW/W is captured.
    - Hit: byte j of the register is updated only when WSTRB[j]=1. BRESP=OKAY (2'b00).
    - Miss: no register changes. BRESP=SLVERR (2'b10).
  - The state then moves to W_RESP.
  - WSTRB=4'b0000 to a hit address gives BRESP=OKAY with no change. REG_WE still pulses.
- Read engine states: R_IDLE, R_DATA.
  - The ARVALID&ARREADY handshake registers RDATA: the register value on a hit; 32'h0 with RRESP=SLVERR on a miss.
  - RDATA/RRESP stay stable while RVALID=1 && RREADY=0.
- Simultaneous read and write to the same register in one edge: the read returns the pre-write value.
- Both engines are fully independent. Neither stalls the other.

## Timing
- Reset values: AWREADY=WREADY=ARREADY=0, BVALID=RVALID=0, BRESP=RRESP=2'b00, RDATA=0, REG_Q=0, REG_WE=0, both engines idle.
- All outputs are registered. The READY signals rise at the first ACLK edge after ARESET falls.
- Write: commit edge k → BVALID=1 and REG_WE pulse from cycle k+1. On the BVALID&BREADY edge, BVALID falls and AWREADY/WREADY rise in the same edge. Best case is one write per 2 cycles.
- Read: AR handshake edge k → RVALID=1 from cycle k+1, ARREADY=0 while RVALID=1. On the RVALID&RREADY edge, RVALID falls and ARREADY rises. Best case is one read per 2 cycles.
- BVALID and RVALID never depend combinationally on BREADY/RREADY.
- ARESET asserted mid-transaction: immediate return to reset values. Partial AW/W captures are discarded, and any in-flight write not yet committed has no effect.

## Structure
- Shared package axil_pkg:
  - resp_t (OKAY=2'b00, EXOKAY=2'b01, SLVERR=2'b10, DECERR=2'b11).
  - wr_state_t and rd_state_t enums.
  - DATA_W=32, STRB_W=4.
- Sub-module axils_wr_ch holds the write engine (AW/W capture, decode, B response) and outputs a commit index/data/strobe/valid. The top level holds the register array, REG_WE, and the read engine.

## Test plan
- Reset then AW+W in the same cycle: addr BASE+0x8, data 32'hDEADBEEF, strb 4'hF → BVALID cycle+1, BRESP=00, REG_Q[95:64]=DEADBEEF, REG_WE=16'h0004 for one cycle.
- W arrives 3 cycles before AW: addr 0x4, data 32'h11223344, strb 4'b0101 over 32'hAAAAAAAA → reg1=32'hAA22AA44. WREADY is low until the B handshake.
- Read of addr 0x40 with NUM_REGS=16 → RDATA=0, RRESP=2'b10. Write to 0x40 → BRESP=2'b10, no REG_WE, REG_Q unchanged.
- BREADY/RREADY held low 5 cycles → BVALID/RVALID, BRESP, RDATA stable. AWREADY/WREADY/ARREADY remain 0 until the handshake.
- Same-edge write 32'h5 and read of reg3 holding 32'h9 → RDATA=32'h9. The next read returns 32'h5.
- ARESET pulsed after AW capture, before W → no register change, BVALID=0, all registers 0.
